// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// regfile_mp : multi-port register file with write bypass and busy scoreboard
// Revision   : 1.0
// ============================================================================
module regfile_mp #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 1,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*XLEN-1:0]  rdata,
  output logic [NRD-1:0]       rbusy,
  input  logic [NWR-1:0]       wen,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NWR*XLEN-1:0]  wdata,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic [NREGS-1:0]     busy_vec
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NWR-1:0]   w_wr_ok;
  logic             w_iss_ok;

  // A write or issue aimed at a hard-wired zero register is dropped here once.
  generate
    for (genvar j = 0; j < NWR; j++) begin : g_wr
      assign w_wr_ok[j] = wen[j] && !(ZERO_R0 && waddr[j*AW +: AW] == '0);
    end
  endgenerate

  assign w_iss_ok = iss_valid && !(ZERO_R0 && iss_rd == '0);

  // Later ports overwrite earlier ones; the issue reservation is applied last
  // so a new producer outranks a completing one on the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (w_wr_ok[j]) begin
          r_regs[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
          r_busy[waddr[j*AW +: AW]] <= 1'b0;
        end
      end
      if (w_iss_ok) begin
        r_busy[iss_rd] <= 1'b1;
      end
    end
  end

  generate
    for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   w_ra;
      logic            w_hit;
      logic [XLEN-1:0] w_byp;
      logic            w_iss_hit;
      logic [XLEN-1:0] w_rd;

      assign w_ra = raddr[i*AW +: AW];

      always_comb begin
        w_hit = 1'b0;
        w_byp = '0;
        for (int j = 0; j < NWR; j++) begin
          if (w_wr_ok[j] && waddr[j*AW +: AW] == w_ra) begin
            w_hit = 1'b1;
            w_byp = wdata[j*XLEN +: XLEN];
          end
        end
      end

      assign w_iss_hit = w_iss_ok && (iss_rd == w_ra);

      assign w_rd = (ZERO_R0 && w_ra == '0) ? '0 :
                    (BYPASS && w_hit)       ? w_byp :
                                              r_regs[w_ra];

      assign rdata[i*XLEN +: XLEN] = rst ? '0 : w_rd;
      assign rbusy[i] = !rst && r_busy[w_ra] && !(BYPASS && w_hit && !w_iss_hit);
    end
  endgenerate

  assign busy_vec = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// tb_regfile_mp : directed/table checks of two regfile_mp configurations
// Revision      : 1.0
// ============================================================================
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Config A: 32x32, 2 read, 2 write, zero r0, bypass
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic [1:0]  a_rbusy;
  logic [1:0]  a_wen;
  logic [9:0]  a_waddr;
  logic [63:0] a_wdata;
  logic        a_iss;
  logic [4:0]  a_ird;
  logic [31:0] a_busy;

  // Config B: 16x64, 4 read, 1 write, r0 writable, no bypass
  logic [15:0]  b_raddr;
  logic [255:0] b_rdata;
  logic [3:0]   b_rbusy;
  logic [0:0]   b_wen;
  logic [3:0]   b_waddr;
  logic [63:0]  b_wdata;
  logic         b_iss;
  logic [3:0]   b_ird;
  logic [15:0]  b_busy;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
    .wen(a_wen), .waddr(a_waddr), .wdata(a_wdata), .iss_valid(a_iss), .iss_rd(a_ird),
    .busy_vec(a_busy));

  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4), .NWR(1), .ZERO_R0(1'b0), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
    .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata), .iss_valid(b_iss), .iss_rd(b_ird),
    .busy_vec(b_busy));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [1:0]  wen;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iss;
    logic [4:0]  ird;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic [31:0] ebv;
  } vec_t;

  localparam int NV = 20;
  vec_t va [NV];

  task automatic bset(input logic w, input logic [3:0] wa, input logic [63:0] wd,
                      input logic is, input logic [3:0] ir, input logic [15:0] ra);
    b_wen   = w;
    b_waddr = wa;
    b_wdata = wd;
    b_iss   = is;
    b_ird   = ir;
    b_raddr = ra;
  endtask

  localparam logic [63:0] FILL = 64'h0101010101010101;
  logic [63:0]  m  [16];
  logic [15:0]  mb;
  logic [255:0] e;
  int           ra [4];
  logic         rw, ri;
  logic [3:0]   rwa, rir;
  logic [63:0]  rwd;

  initial begin
    //        wen   wa0   wd0            wa1   wd1     iss   ird   ra0   ra1   e0             e1             eb     ebv
    va[0]  = '{2'b01, 5'd5, 32'h1234,     5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd0, 32'h1234,      32'h0,         2'b00, 32'h0};
    va[1]  = '{2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0,  1'b1, 5'd0, 5'd0, 5'd5, 32'h0,         32'h1234,      2'b00, 32'h0};
    va[2]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd0, 32'h0,         32'h0,         2'b00, 32'h0};
    va[3]  = '{2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd7, 32'hA5A5A5A5,  32'hA5A5A5A5,  2'b00, 32'h0};
    va[4]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd5, 32'hA5A5A5A5,  32'h1234,      2'b00, 32'h0};
    va[5]  = '{2'b11, 5'd3, 32'h11,       5'd3, 32'h22, 1'b0, 5'd0, 5'd3, 5'd3, 32'h22,        32'h22,        2'b00, 32'h0};
    va[6]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd2, 32'h22,        32'h0,         2'b00, 32'h0};
    va[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd3, 32'h0,         32'h22,        2'b00, 32'h0};
    va[8]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd9, 32'h0,         32'h0,         2'b11, 32'h200};
    va[9]  = '{2'b01, 5'd9, 32'h55,       5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd9, 32'h55,        32'h55,        2'b00, 32'h200};
    va[10] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd9, 32'h55,        32'h55,        2'b00, 32'h0};
    va[11] = '{2'b10, 5'd0, 32'h0,        5'd9, 32'h66, 1'b1, 5'd9, 5'd9, 5'd9, 32'h66,        32'h66,        2'b00, 32'h0};
    va[12] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd9, 32'h66,        32'h66,        2'b11, 32'h200};
    va[13] = '{2'b01, 5'd9, 32'h77,       5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd5, 32'h77,        32'h1234,      2'b01, 32'h200};
    va[14] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd5, 32'h77,        32'h1234,      2'b01, 32'h200};
    va[15] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd5, 32'h77,        32'h1234,      2'b01, 32'h200};
    va[16] = '{2'b01, 5'd9, 32'h88,       5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd3, 32'h88,        32'h22,        2'b00, 32'h200};
    va[17] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd7, 32'h88,        32'hA5A5A5A5,  2'b00, 32'h0};
    va[18] = '{2'b11, 5'd4, 32'h44,       5'd6, 32'h66, 1'b0, 5'd0, 5'd4, 5'd6, 32'h44,        32'h66,        2'b00, 32'h0};
    va[19] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd4, 5'd6, 32'h44,        32'h66,        2'b00, 32'h0};

    a_raddr = '0; a_wen = '0; a_waddr = '0; a_wdata = '0; a_iss = 1'b0; a_ird = '0;
    bset(1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 16'h0);

    // Reset state, with a write and issue held on the ports that must not land
    repeat (2) tick();
    a_wen = 2'b01; a_waddr = {5'd0, 5'd5}; a_wdata = {32'h0, 32'hFFFF};
    a_iss = 1'b1; a_ird = 5'd5; a_raddr = {5'd0, 5'd5};
    tick();
    #3;
    chk("rst_a_rdata", a_rdata, 64'h0);
    chk("rst_a_busy", a_busy, 32'h0);
    chk("rst_b_rdata", b_rdata, 256'h0);
    chk("rst_b_busy", b_busy, 16'h0);
    tick();
    a_wen = '0; a_iss = 1'b0; a_raddr = {5'd0, 5'd5};
    rst = 1'b0;
    #3;
    chk("rst_a_write_dropped", a_rdata[31:0], 32'h0);
    tick();

    for (int i = 0; i < NV; i++) begin
      a_wen   = va[i].wen;
      a_waddr = {va[i].wa1, va[i].wa0};
      a_wdata = {va[i].wd1, va[i].wd0};
      a_iss   = va[i].iss;
      a_ird   = va[i].ird;
      a_raddr = {va[i].ra1, va[i].ra0};
      #3;
      chk($sformatf("vecA[%0d].rd0", i), a_rdata[31:0], va[i].e0);
      chk($sformatf("vecA[%0d].rd1", i), a_rdata[63:32], va[i].e1);
      chk($sformatf("vecA[%0d].rbusy", i), a_rbusy, va[i].eb);
      chk($sformatf("vecA[%0d].busy_vec", i), a_busy, va[i].ebv);
      tick();
    end

    // Asynchronous reset between edges clears data and reservations at once
    a_wen = '0; a_iss = 1'b1; a_ird = 5'd9; a_raddr = {5'd9, 5'd5};
    tick();
    a_iss = 1'b0;
    #1;
    chk("arst_pre_x5", a_rdata[31:0], 32'h1234);
    chk("arst_pre_rbusy", a_rbusy, 2'b10);
    chk("arst_pre_busy", a_busy, 32'h200);
    a_wen = 2'b01; a_waddr = {5'd0, 5'd5}; a_wdata = {32'h0, 32'hFFFF};
    a_iss = 1'b1; a_ird = 5'd12;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_rdata", a_rdata, 64'h0);
    chk("arst_rbusy", a_rbusy, 2'b00);
    chk("arst_busy", a_busy, 32'h0);
    tick();
    a_wen = '0; a_iss = 1'b0; a_raddr = {5'd12, 5'd5};
    rst = 1'b0;
    #3;
    chk("arst_post_rdata", a_rdata, 64'h0);
    chk("arst_post_busy", a_busy, 32'h0);
    chk("arst_post_rbusy", a_rbusy, 2'b00);
    tick();

    // Config B: writable r0, no bypass, reservations without forwarding
    bset(1'b1, 4'd0, 64'hDEADBEEF, 1'b1, 4'd0, {4'd3, 4'd2, 4'd1, 4'd0});
    #3;
    chk("b_x0_old", b_rdata, 256'h0);
    chk("b_busy0_pre", b_busy, 16'h0);
    tick();
    bset(1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 16'h0);
    #3;
    chk("b_x0_new", b_rdata[63:0], 64'hDEADBEEF);
    chk("b_x0_rbusy", b_rbusy, 4'b1111);
    chk("b_x0_busy_vec", b_busy, 16'h0001);
    tick();
    bset(1'b1, 4'd7, 64'hA5A5A5A5, 1'b1, 4'd9, {4'd0, 4'd0, 4'd0, 4'd7});
    #3;
    chk("b_x7_old", b_rdata[63:0], 64'h0);
    tick();
    bset(1'b0, 4'd0, 64'h0, 1'b0, 4'd0, {4'd0, 4'd0, 4'd0, 4'd7});
    #3;
    chk("b_x7_new", b_rdata[63:0], 64'hA5A5A5A5);
    chk("b_busy_x0_x9", b_busy, 16'h0201);
    tick();
    bset(1'b1, 4'd9, 64'h55, 1'b0, 4'd0, {4'd7, 4'd7, 4'd9, 4'd7});
    #3;
    chk("b_x9_old", b_rdata[127:64], 64'h0);
    chk("b_x9_rbusy_nobyp", b_rbusy, 4'b0010);
    tick();
    bset(1'b0, 4'd0, 64'h0, 1'b0, 4'd0, {4'd7, 4'd7, 4'd9, 4'd7});
    #3;
    chk("b_x9_new", b_rdata[127:64], 64'h55);
    chk("b_x9_rbusy_clr", b_rbusy, 4'b0000);
    chk("b_x9_busy_vec", b_busy, 16'h0001);
    tick();

    // Fill all registers, then read four distinct addresses per cycle
    for (int k = 0; k < 16; k++) begin
      bset(1'b1, 4'(k), 64'(k) * FILL, 1'b0, 4'd0, 16'h0);
      tick();
    end
    bset(1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 16'h0);
    for (int c = 0; c < 4; c++) begin
      ra[0] = 4 * c + 2; ra[1] = 4 * c; ra[2] = 4 * c + 3; ra[3] = 4 * c + 1;
      b_raddr = {4'(ra[3]), 4'(ra[2]), 4'(ra[1]), 4'(ra[0])};
      for (int i = 0; i < 4; i++) e[i*64 +: 64] = 64'(ra[i]) * FILL;
      #3;
      chk($sformatf("b_fill_read[%0d]", c), b_rdata, e);
      chk($sformatf("b_fill_busy[%0d]", c), b_busy, 16'h0);
      tick();
    end

    // Random traffic against a reference model of the non-bypass configuration
    for (int k = 0; k < 16; k++) m[k] = 64'(k) * FILL;
    mb = '0;
    for (int n = 0; n < 10000; n++) begin
      rw  = 1'($urandom_range(0, 1));
      rwa = 4'($urandom_range(0, 15));
      rwd = {$urandom, $urandom};
      ri  = ($urandom_range(0, 3) == 0);
      rir = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) ra[i] = $urandom_range(0, 15);
      bset(rw, rwa, rwd, ri, rir, {4'(ra[3]), 4'(ra[2]), 4'(ra[1]), 4'(ra[0])});
      for (int i = 0; i < 4; i++) e[i*64 +: 64] = m[ra[i]];
      #3;
      chk($sformatf("b_rand[%0d].rdata", n), b_rdata, e);
      chk($sformatf("b_rand[%0d].busy", n), {b_rbusy, b_busy},
          {mb[ra[3]], mb[ra[2]], mb[ra[1]], mb[ra[0]], mb});
      tick();
      if (rw) begin
        m[rwa]  = rwd;
        mb[rwa] = 1'b0;
      end
      if (ri) mb[rir] = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file. Successor to the single-write, dual-read core register heap.
- Adds configurable width, depth, read-port count and write-port count.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard for in-order issue hazard detection.
- Sits between the decode/issue stage (reads, busy check, destination reservation) and the writeback stage or stages.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2. The local address width is AW = $clog2(NREGS).
- NRD, 2, number of read ports, 1..4.
- NWR, 1, number of write ports, 1..3.
- ZERO_R0, 1, when 1, register 0 always reads 0, ignores writes, and is never busy.
- BYPASS, 1, when 1, a read of a register being written in the same cycle returns the write data.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- raddr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- rdata  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- rbusy  out  NRD  per-read-port busy flag of the addressed register.
- wen  in  NWR  write enables.
- waddr  in  NWR*AW  write addresses.
- wdata  in  NWR*XLEN  write data.
- iss_valid  in  1  issue strobe: reserve the destination register.
- iss_rd  in  AW  destination register being reserved.
- busy_vec  out  NREGS  full scoreboard, for debug and trace.

Behaviour:
- Reset, asynchronous on rst high:
  - All registers are 0 and all busy bits are 0 immediately, without waiting for a clock edge.
  - While rst is high, rdata reads 0 and rbusy and busy_vec are 0.
  - Writes and issues presented during reset are ignored.
  - Reset asserted mid-operation discards every in-flight reservation.
- Storage: NREGS x XLEN flops. Register k updates only on a rising clk edge with rst low.
- Write:
  - Port j writes wdata[j] to waddr[j] when wen[j]=1.
  - If ZERO_R0=1 and waddr[j]=0, the write is dropped.
  - If several ports target the same register in one cycle, the highest-index port wins. No error is flagged.
- Read, combinational, zero latency: rdata[i] = regs[raddr[i]].
  - With ZERO_R0=1, address 0 always yields 0.
  - With BYPASS=1, if any enabled write port targets raddr[i] (excluding r0 when ZERO_R0=1), rdata[i] returns that port's wdata. The same highest-index priority applies.
  - With BYPASS=0, rdata shows the old value until the cycle after the write.
- Scoreboard, one busy bit per register:
  - Set on a rising edge when iss_valid=1 at address iss_rd.
  - Cleared on a rising edge when any enabled write port targets that register.
  - Simultaneous issue and write to the same register: busy ends at 1, because the new producer takes precedence. Data is still written.
  - Issue to r0 with ZERO_R0=1: no effect.
  - Issue to an already-busy register: stays 1. There is no count; a single write clears it.
  - Write to a non-busy register: busy stays 0 and the write proceeds normally.
- rbusy[i] = busy[raddr[i]].
  - With BYPASS=1, rbusy[i] is forced to 0 when a same-cycle enabled write targets raddr[i] and no same-cycle issue targets it. This gives the consumer valid data in that cycle.
  - With BYPASS=0, rbusy reflects the registered busy bit only.
- busy_vec = registered busy bits.
- Out-of-range addresses cannot occur because NREGS is a power of two.

Test Plan:
- Reset: drive rst high asynchronously between edges after writing 0x1234 to x5 → rdata for x5 is 0 and busy_vec is 0 before the next edge. Writes presented during reset are not applied.
- x0 handling: with ZERO_R0=1, write 0xDEADBEEF to x0 and issue x0 → x0 reads 0 and busy_vec[0]=0. With ZERO_R0=0, x0 reads 0xDEADBEEF the cycle after the write.
- Bypass: with BYPASS=1, write 0xA5A5A5A5 to x7 while raddr0=x7 in the same cycle → rdata0=0xA5A5A5A5 combinationally. With BYPASS=0 → the old value, then 0xA5A5A5A5 in the next cycle.
- Multi-write conflict: with NWR=2, both ports write x3 with 0x11 and 0x22 → x3=0x22. A bypassed read in that cycle also returns 0x22.
- Scoreboard sequence:
  - Issue x9 → rbusy=1 next cycle.
  - Write x9=0x55 → in that cycle rbusy=0 (BYPASS=1) and rdata=0x55; busy_vec[9]=0 afterwards.
  - Issue and write x9 in the same cycle → busy_vec[9]=1 and x9 holds the new data.
- Port scaling: with NRD=4, XLEN=64, NREGS=16, fill all registers with the value k*0x0101010101010101 and read four distinct addresses each cycle → every port returns the correct value. Random reads and writes are checked against a reference model for 10k cycles.
